// File: rtl/multi_toggle_reg.sv
// State register with a scheduled per-bit toggle table keyed on step number.
// Optional TOGGLE_REARM_EN adds a rearm input that clears all fired flags.
module multi_toggle_reg #(
  parameter int WIDTH       = 64,
  parameter int W_LOG_2     = 6,
  parameter int NUM_TOGGLES = 4,
  parameter int T_LOG_2     = 2,
  parameter int CNT_W       = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   full_load,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [WIDTH-1:0]       init_state,
  input  logic [W_LOG_2-1:0]     sel,
  input  logic [CNT_W-1:0]       step_number,
  input  logic                   cfg_we,
  input  logic [T_LOG_2-1:0]     cfg_idx,
  input  logic [CNT_W-1:0]       cfg_round,
  input  logic [W_LOG_2-1:0]     cfg_bit,
  input  logic [1:0]             cfg_mode,
`ifdef TOGGLE_REARM_EN
  input  logic                   rearm,
`endif
  output logic [WIDTH-1:0]       data_out,
  output logic [NUM_TOGGLES-1:0] fired,
  output logic                   fire_pulse
);

  logic [CNT_W-1:0]       round_q [NUM_TOGGLES];
  logic [W_LOG_2-1:0]     tbit_q  [NUM_TOGGLES];
  logic [1:0]             mode_q  [NUM_TOGGLES];
  logic [NUM_TOGGLES-1:0] hit;
  logic [NUM_TOGGLES-1:0] fired_nxt;
  logic [WIDTH-1:0]       nxt;
  logic                   clr_all;

`ifdef TOGGLE_REARM_EN
  assign clr_all = rearm;
`else
  assign clr_all = 1'b0;
`endif

  // A same-cycle rewrite of an entry suppresses that entry's firing.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_TOGGLES; i++) begin
      hit[i] = load && (mode_q[i] != 2'b00) && !fired[i]
            && (step_number == round_q[i])
            && !(cfg_we && (cfg_idx == T_LOG_2'(i)));
    end
  end

  always_comb begin
    nxt = data_out;
    if (load) begin
      if (full_load) begin
        nxt = data_in;
      end else if (int'(sel) < WIDTH) begin
        nxt[sel] = data_in[sel];
      end
    end
    for (int i = 0; i < NUM_TOGGLES; i++) begin
      if (hit[i] && (int'(tbit_q[i]) < WIDTH)) begin
        unique case (mode_q[i])
          2'b01:   nxt[tbit_q[i]] = ~nxt[tbit_q[i]];
          2'b10:   nxt[tbit_q[i]] = 1'b0;
          2'b11:   nxt[tbit_q[i]] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    fired_nxt = fired | hit;
    for (int i = 0; i < NUM_TOGGLES; i++) begin
      if (cfg_we && (cfg_idx == T_LOG_2'(i))) begin
        fired_nxt[i] = 1'b0;
      end
    end
    if (clr_all) begin
      fired_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out   <= init_state;
      fired      <= '0;
      fire_pulse <= 1'b0;
      for (int i = 0; i < NUM_TOGGLES; i++) begin
        round_q[i] <= '0;
        tbit_q[i]  <= '0;
        mode_q[i]  <= 2'b00;
      end
    end else begin
      data_out   <= nxt;
      fired      <= fired_nxt;
      fire_pulse <= |hit;
      for (int i = 0; i < NUM_TOGGLES; i++) begin
        if (cfg_we && (cfg_idx == T_LOG_2'(i))) begin
          round_q[i] <= cfg_round;
          tbit_q[i]  <= cfg_bit;
          mode_q[i]  <= cfg_mode;
        end
      end
    end
  end

endmodule
